// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave byte engine, MSB first: oversamples the SPI pins on clk,
// assembles received bytes and serialises one requested byte onto MISO.
module spi_slave_phy #(
  parameter int SYNC_STAGES = 3,
  parameter int BYTE_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ncs,
  output logic              miso,
  output logic              miso_oe,
  input  logic              iCall,
  input  logic [BYTE_W-1:0] iData,
  output logic [1:0]        oDone,
  output logic [BYTE_W-1:0] oData
);

  localparam int               CNT_W    = $clog2(BYTE_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, mosi_s, ncs_s;
  logic                   sclk_r, sclk_f;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
  logic [BYTE_W-1:0] tx_sh_q, tx_sh_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [BYTE_W-1:0] rx_next;
  logic              tx_busy_q, tx_busy_d;
  logic              done_hold_q, done_hold_d;
  logic [1:0]        done_q, done_d;
  logic              shifting, load;

  // NOTE: synchronisers reset to the idle bus (sclk low, ncs high) so no edge fires out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_r = sclk_s & ~sclk_prev_q;
  assign sclk_f = ~sclk_s & sclk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!ncs_s) state_d = SHIFT;
      SHIFT:   if (ncs_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifting = (state_q == SHIFT);
    load     = shifting && iCall && !tx_busy_q && !done_hold_q &&
               (bit_cnt_q == '0) && !sclk_r && !sclk_f;
    miso     = tx_busy_q & tx_sh_q[BYTE_W-1];
    miso_oe  = ~ncs_s;
  end

  // NOTE: every _d gets a default before any branch so no path can infer a latch.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    tx_busy_d   = tx_busy_q;
    data_d      = data_q;
    done_hold_d = 1'b0;
    done_d      = 2'b00;
    rx_next     = {rx_sh_q[BYTE_W-2:0], mosi_s};
    if (!shifting) begin
      bit_cnt_d = '0;
      rx_sh_d   = '0;
      tx_busy_d = 1'b0;
    end else begin
      if (load) begin
        tx_sh_d   = iData;
        tx_busy_d = 1'b1;
      end
      if (sclk_r) begin
        rx_sh_d   = rx_next;
        bit_cnt_d = bit_cnt_q + 1'b1;
        // A completing byte strobes even if ncs rises in this same cycle.
        if (bit_cnt_q == LAST_BIT) begin
          data_d    = rx_next;
          done_d[0] = 1'b1;
          if (tx_busy_q) begin
            done_d[1]   = 1'b1;
            tx_busy_d   = 1'b0;
            done_hold_d = 1'b1;
          end
        end
      end
      if (sclk_f && tx_busy_q && (bit_cnt_q != '0)) tx_sh_d = {tx_sh_q[BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      tx_busy_q   <= 1'b0;
      done_hold_q <= 1'b0;
      done_q      <= 2'b00;
      data_q      <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      tx_busy_q   <= tx_busy_d;
      done_hold_q <= done_hold_d;
      done_q      <= done_d;
      data_q      <= data_d;
    end
  end

  assign oDone = done_q;
  assign oData = data_q;

endmodule

// File: tb/tb_spi_slave_phy.sv
// Bench for spi_slave_phy: a master model drives SCLK at clk/8 and a control-stage model
// answers oDone[1] by dropping iCall one cycle later; results are compared with sent bytes.
module tb_spi_slave_phy;

  localparam int SYNC_STAGES = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ncs = 1'b1;
  logic       iCall = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       miso, miso_oe;
  logic [1:0] oDone;
  logic [7:0] oData;

  spi_slave_phy #(.SYNC_STAGES(SYNC_STAGES), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ncs(ncs),
    .miso(miso), .miso_oe(miso_oe), .iCall(iCall), .iData(iData),
    .oDone(oDone), .oData(oData)
  );

  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  int         lat_last = 0;
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         tx_alone = 0;
  int         consec_err = 0;
  int         miso_bad = 0;
  bit         miso_watch = 1'b0;
  bit         drop_pending = 1'b0;
  logic [1:0] prev_done = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clk cycle: sample on the falling edge, log strobes, model the control stage.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (oDone[0] === 1'b1) begin
      rx_cnt++;
      lat_last = cyc - rise_cyc;
    end
    if (oDone[1] === 1'b1) begin
      tx_cnt++;
      if (oDone[0] !== 1'b1) tx_alone++;
    end
    if ((oDone & prev_done) != 2'b00) consec_err++;
    prev_done = oDone;
    if (miso_watch && miso !== 1'b0) miso_bad++;
    if (drop_pending) begin
      iCall = 1'b0;
      drop_pending = 1'b0;
    end else if (oDone[1] === 1'b1 && iCall) begin
      drop_pending = 1'b1;
    end
  endtask

  // Mode-0 master: nbits bits MSB first, 4 cycles low then 4 high; MISO sampled at each rise.
  task automatic xfer(input logic [7:0] b, input int nbits, input bit ncs_on_last,
                      output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (4) tick();
      miso_b = {miso_b[6:0], miso};
      sclk = 1'b1;
      rise_cyc = cyc;
      if (ncs_on_last && i == nbits - 1) ncs = 1'b1;
      repeat (4) tick();
      sclk = 1'b0;
    end
  endtask

  task automatic wait_rx(input int prev);
    for (int k = 0; k < 12 && rx_cnt == prev; k++) tick();
  endtask

  task automatic select_dev();
    ncs = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
  endtask

  task automatic deselect_dev();
    ncs = 1'b1;
    repeat (SYNC_STAGES + 3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] mb, rb, rb2, tb;
    logic [7:0] last_rx;
    int         r0, t0, k;
    bit         do_tx;

    // Reset state
    repeat (3) tick();
    check("rst_oDone", oDone, 2'b00);
    check("rst_oData", oData, 8'h00);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // Back-to-back receive, no transmit
    select_dev();
    check("sel_miso_oe", miso_oe, 1'b1);
    r0 = rx_cnt;
    t0 = tx_cnt;
    xfer(8'h06, 8, 1'b0, mb);
    wait_rx(r0);
    check("rx06_cnt", rx_cnt, r0 + 1);
    check("rx06_data", oData, 8'h06);
    check("rx_latency_ok", (lat_last >= SYNC_STAGES + 1) && (lat_last <= SYNC_STAGES + 2), 1'b1);
    xfer(8'hAA, 8, 1'b0, mb);
    wait_rx(r0 + 1);
    check("rxAA_cnt", rx_cnt, r0 + 2);
    check("rxAA_data", oData, 8'hAA);
    check("rx_no_tx", tx_cnt, t0);

    // Transmit response D4 to command 06
    r0 = rx_cnt;
    xfer(8'h06, 8, 1'b0, mb);
    wait_rx(r0);
    check("cmd06_data", oData, 8'h06);
    repeat (2) tick();
    iData = 8'hD4;
    iCall = 1'b1;
    repeat (4) tick();
    t0 = tx_cnt;
    rb = 8'($urandom);
    xfer(rb, 8, 1'b0, mb);
    for (k = 0; k < 12 && tx_cnt == t0; k++) tick();
    check("tx_miso_bits", mb, 8'hD4);
    check("tx_strobe_cnt", tx_cnt, t0 + 1);
    check("tx_with_rx", tx_alone, 0);
    check("tx_rx_data", oData, rb);
    repeat (3) tick();
    rb2 = 8'($urandom);
    xfer(rb2, 8, 1'b0, mb);
    wait_rx(rx_cnt);
    check("no_reload_miso", mb, 8'h00);
    check("no_reload_cnt", tx_cnt, t0 + 1);
    last_rx = rb2;
    repeat (2) tick();

    // Abort after 5 bits of FF with a transmit pending
    deselect_dev();
    select_dev();
    iData = 8'($urandom) | 8'h80;
    iCall = 1'b1;
    repeat (4) tick();
    r0 = rx_cnt;
    t0 = tx_cnt;
    xfer(8'hFF, 5, 1'b0, mb);
    ncs = 1'b1;
    iCall = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
    check("abort_no_rx", rx_cnt, r0);
    check("abort_no_tx", tx_cnt, t0);
    check("abort_oData", oData, last_rx);
    select_dev();
    xfer(8'h3C, 8, 1'b0, mb);
    wait_rx(r0);
    check("post_abort_data", oData, 8'h3C);
    check("post_abort_miso", mb, 8'h00);
    repeat (2) tick();

    // Idle MISO while selected, then miso_oe release
    miso_watch = 1'b1;
    r0 = rx_cnt;
    xfer(8'h55, 8, 1'b0, mb);
    wait_rx(r0);
    check("idle_miso_oe", miso_oe, 1'b1);
    miso_watch = 1'b0;
    check("idle_miso_zero", miso_bad, 0);
    check("idle_data", oData, 8'h55);
    repeat (2) tick();
    ncs = 1'b1;
    k = 0;
    while (miso_oe !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    check("oe_release_ok", k <= SYNC_STAGES + 1, 1'b1);
    repeat (4) tick();

    // ncs rises together with the 8th SCLK rise
    select_dev();
    r0 = rx_cnt;
    xfer(8'hC4, 8, 1'b1, mb);
    wait_rx(r0);
    repeat (SYNC_STAGES + 3) tick();
    check("coinc_cnt", rx_cnt, r0 + 1);
    check("coinc_data", oData, 8'hC4);
    check("coinc_oe", miso_oe, 1'b0);
    select_dev();
    rb = 8'($urandom);
    xfer(rb, 8, 1'b0, mb);
    wait_rx(r0 + 1);
    check("coinc_next_data", oData, rb);
    check("coinc_next_cnt", rx_cnt, r0 + 2);

    // Reset in the middle of a byte
    repeat (2) tick();
    r0 = rx_cnt;
    xfer(8'hF0, 4, 1'b0, mb);
    rst = 1'b1;
    tick();
    check("midrst_oDone", oDone, 2'b00);
    check("midrst_oData", oData, 8'h00);
    check("midrst_miso", miso, 1'b0);
    check("midrst_miso_oe", miso_oe, 1'b0);
    rst = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
    check("midrst_no_rx", rx_cnt, r0);
    xfer(8'hA5, 8, 1'b0, mb);
    wait_rx(r0);
    repeat (2) tick();
    check("midrst_A5_cnt", rx_cnt, r0 + 1);
    check("midrst_A5_data", oData, 8'hA5);

    // Random receive/transmit traffic against the byte-level model
    for (int it = 0; it < 6; it++) begin
      rb = 8'($urandom);
      tb = 8'($urandom);
      do_tx = 1'($urandom_range(0, 1));
      if (do_tx) begin
        iData = tb;
        iCall = 1'b1;
      end
      repeat (6) tick();
      r0 = rx_cnt;
      t0 = tx_cnt;
      xfer(rb, 8, 1'b0, mb);
      wait_rx(r0);
      repeat (2) tick();
      check("rand_rx_cnt", rx_cnt, r0 + 1);
      check("rand_rx_data", oData, rb);
      check("rand_miso", mb, do_tx ? tb : 8'h00);
      check("rand_tx_cnt", tx_cnt, t0 + (do_tx ? 1 : 0));
    end

    deselect_dev();
    check("no_consecutive_done", consec_err, 0);
    check("tx_always_with_rx", tx_alone, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
